// File: rtl/test_frame_source.sv
// Push-button triggered frame generator: header, FRAME_WORDS payload words and an XOR trailer,
// emitted as single-cycle valid strobes that stall while pause_in is high.
module test_frame_source #(
  parameter int          DEBOUNCE_CYCLES = 270000,
  parameter int          FRAME_WORDS     = 256,
  parameter logic [15:0] HEADER_MAGIC    = 16'hA5A5
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        trigger_in,
  input  logic        pause_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        busy_out,
  output logic [15:0] frame_cnt_out
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]   IDX_LAST = 16'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;

  logic          sync1, sync2, deb, deb_d;
  logic [DW-1:0] deb_cnt;
  logic          start;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= trigger_in;
      sync2 <= sync1;
      deb_d <= deb;
      if (sync2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb     <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign start = deb & ~deb_d;

  state_t      state, state_nxt;
  logic [15:0] idx, idx_nxt;
  logic [31:0] csum, csum_nxt;
  logic [31:0] word, data_nxt;
  logic        valid_nxt, busy_nxt;
  logic [15:0] cnt_nxt;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    csum_nxt  = csum;
    data_nxt  = data_out;
    valid_nxt = 1'b0;
    busy_nxt  = busy_out;
    cnt_nxt   = frame_cnt_out;
    word      = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = HEADER;
          busy_nxt  = 1'b1;
          csum_nxt  = '0;
          idx_nxt   = '0;
        end
      end
      HEADER: begin
        word = {HEADER_MAGIC, frame_cnt_out};
        if (!pause_in) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        word = {frame_cnt_out, idx};
        if (!pause_in) begin
          if (idx == IDX_LAST) state_nxt = TRAILER;
          else idx_nxt = idx + 16'd1;
        end
      end
      TRAILER: begin
        word = csum;
        if (!pause_in) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          cnt_nxt   = frame_cnt_out + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Any non-idle state emits its word on an unpaused edge; the trailer folding itself in is harmless.
    if (state != IDLE && !pause_in) begin
      data_nxt  = word;
      valid_nxt = 1'b1;
      csum_nxt  = csum ^ word;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      idx           <= '0;
      csum          <= '0;
      data_out      <= '0;
      valid_out     <= 1'b0;
      busy_out      <= 1'b0;
      frame_cnt_out <= '0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      csum          <= csum_nxt;
      data_out      <= data_nxt;
      valid_out     <= valid_nxt;
      busy_out      <= busy_nxt;
      frame_cnt_out <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_test_frame_source.sv
// Bench for test_frame_source: table of frame scenarios checked through an expected-word queue,
// plus hand sequences for glitch rejection, reset-mid-frame and counter wrap.
module tb_test_frame_source;
  localparam int          D     = 4;
  localparam int          FW    = 4;
  localparam logic [15:0] MAGIC = 16'hA5A5;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        trigger_in = 1'b0;
  logic        pause_in = 1'b0;
  logic [31:0] data_out;
  logic        valid_out;
  logic        busy_out;
  logic [15:0] frame_cnt_out;

  test_frame_source #(.DEBOUNCE_CYCLES(D), .FRAME_WORDS(FW), .HEADER_MAGIC(MAGIC)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .trigger_in(trigger_in), .pause_in(pause_in),
    .data_out(data_out), .valid_out(valid_out), .busy_out(busy_out),
    .frame_cnt_out(frame_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          pre;        // 0 none, 1 reset during payload idx 1, 2 force counter to FFFF
    int          pause_at;   // words already emitted when pause is raised, -1 for none
    int          pause_len;
    bit          busy_press;
    logic [31:0] exp_header;
    logic [31:0] exp_trailer;
    logic [15:0] exp_cnt;
    int          exp_gaps;
  } frame_rec_t;

  frame_rec_t  tbl[6];
  logic [31:0] exp_q[$];
  logic [15:0] seq = 16'h0000;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] header, input logic [31:0] trailer);
    exp_q.push_back(header);
    for (int i = 0; i < FW; i++) exp_q.push_back({seq, 16'(i)});
    exp_q.push_back(trailer);
  endtask

  task automatic sb_compare();
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_word: got %h expected none", data_out);
    end else begin
      check("word", data_out, exp_q.pop_front());
    end
  endtask

  task automatic run_frame(input frame_rec_t r);
    int          words, gaps, lat, pcount;
    bit          started, done, stable_ok;
    logic [31:0] last;
    words = 0; gaps = 0; lat = -1; pcount = 0;
    started = 0; done = 0; stable_ok = 1; last = '0;
    trigger_in = 1'b0;
    repeat (10) @(negedge clk_in);
    push_frame(r.exp_header, r.exp_trailer);
    trigger_in = 1'b1;
    for (int e = 1; e <= 300 && !done; e++) begin
      @(negedge clk_in);
      if (valid_out) begin
        if (!started) lat = e;
        started = 1;
        words++;
        sb_compare();
        last = data_out;
      end else if (started) begin
        gaps++;
        if (data_out !== last) stable_ok = 0;
      end
      if (started && !busy_out) done = 1;
      if (r.busy_press && e == 9)  trigger_in = 1'b0;
      if (r.busy_press && e == 17) trigger_in = 1'b1;
      if (words == r.pause_at && pcount < r.pause_len) begin
        pause_in = 1'b1;
        pcount++;
      end else begin
        pause_in = 1'b0;
      end
    end
    pause_in = 1'b0;
    check("frame_done", 32'(done), 32'd1);
    check("latency", lat, D + 4);
    check("word_count", words, FW + 2);
    check("gap_count", gaps, r.exp_gaps);
    check("gap_data_stable", 32'(stable_ok), 32'd1);
    check("frame_cnt", 32'(frame_cnt_out), 32'(r.exp_cnt));
    check("busy_after", 32'(busy_out), 32'd0);
    check("queue_empty", exp_q.size(), 0);
    seq = seq + 16'd1;
  endtask

  task automatic idle_check();
    int extra;
    extra = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (valid_out || busy_out) extra++;
    end
    check("no_extra_frame", extra, 0);
  endtask

  initial begin
    int words;
    int extra;
    tbl[0] = '{0, -1, 0,  1'b0, 32'hA5A5_0000, 32'hA5A5_0000, 16'h0001, 0};
    tbl[1] = '{0, -1, 0,  1'b0, 32'hA5A5_0001, 32'hA5A5_0001, 16'h0002, 0};
    tbl[2] = '{0, 3,  3,  1'b0, 32'hA5A5_0002, 32'hA5A5_0002, 16'h0003, 3};
    tbl[3] = '{0, 1,  20, 1'b1, 32'hA5A5_0003, 32'hA5A5_0003, 16'h0004, 20};
    tbl[4] = '{1, -1, 0,  1'b0, 32'hA5A5_0000, 32'hA5A5_0000, 16'h0001, 0};
    tbl[5] = '{2, -1, 0,  1'b0, 32'hA5A5_FFFF, 32'hA5A5_FFFF, 16'h0000, 0};

    #2 rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    check("rst_data", data_out, 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_busy", 32'(busy_out), 32'h0);
    check("rst_cnt", 32'(frame_cnt_out), 32'h0);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);

    // 3-cycle pulse is shorter than the debounce window
    trigger_in = 1'b1;
    repeat (3) @(negedge clk_in);
    trigger_in = 1'b0;
    extra = 0;
    repeat (30) begin
      @(negedge clk_in);
      if (valid_out || busy_out) extra++;
    end
    check("glitch_rejected", extra, 0);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].pre == 1) begin
        trigger_in = 1'b0;
        repeat (10) @(negedge clk_in);
        push_frame({MAGIC, seq}, 32'h0);
        trigger_in = 1'b1;
        words = 0;
        for (int e = 0; e < 100 && words < 2; e++) begin
          @(negedge clk_in);
          if (valid_out) begin
            words++;
            sb_compare();
          end
        end
        check("pre_reset_words", words, 2);
        rst_in = 1'b1;
        trigger_in = 1'b0;
        #1;
        check("midrst_data", data_out, 32'h0);
        check("midrst_valid", 32'(valid_out), 32'h0);
        check("midrst_busy", 32'(busy_out), 32'h0);
        check("midrst_cnt", 32'(frame_cnt_out), 32'h0);
        exp_q.delete();
        seq = 16'h0000;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
      end else if (tbl[i].pre == 2) begin
        @(negedge clk_in);
        force dut.frame_cnt_out = 16'hFFFF;
        @(negedge clk_in);
        release dut.frame_cnt_out;
        @(negedge clk_in);
        check("forced_cnt", 32'(frame_cnt_out), 32'h0000_FFFF);
        seq = 16'hFFFF;
      end
      run_frame(tbl[i]);
      idle_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/test_frame_source.md
# test_frame_source

- Upstream stage of the FTDI streaming path: turns a debounced push-button press into one self-checking frame of 32-bit words, emitted as a valid-strobed stream into the CDC data gateway.
- Runs entirely in the user clock domain (27 MHz).
- Accepts a pause signal from the gateway's FIFO fill level so that no frame word is ever dropped.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 270000: consecutive stable cycles needed to accept a new trigger level (10 ms at 27 MHz); minimum 2.
- FRAME_WORDS, 256: payload words per frame; legal range 1..65535.
- HEADER_MAGIC, 16'hA5A5: upper half of the header word.

Ports:
- clk_in, input, 1: user clock. One clock; every register is in this domain.
- rst_in, input, 1: reset. Asynchronous, active-high.
- trigger_in, input, 1: raw button, asynchronous, active-high.
- pause_in, input, 1: gateway FIFO almost-full, synchronous to clk_in.
- data_out, output, 32: frame word.
- valid_out, output, 1: data_out is valid this cycle; single-cycle strobe per word.
- busy_out, output, 1: a frame is in progress.
- frame_cnt_out, output, 16: number of completed frames, modulo 2^16.

## Operation
- **Reset values:** every output is 0. The FSM is in IDLE, and the debounced level, debounce counter, word index, checksum and frame sequence are all 0.
- **Trigger path:**
  - trigger_in passes through a 2-flop synchronizer.
  - The debounce counter clears whenever the synchronized level equals the debounced level. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and still differs, the debounced level takes the new value and the counter clears.
  - A 0->1 edge of the debounced level is a start request for one cycle.
- **Start requests:** accepted only in IDLE. A request arriving while busy is discarded, not queued.
- **FSM states:** IDLE -> HEADER -> PAYLOAD -> TRAILER -> IDLE.
  - IDLE -> HEADER on a start request. busy_out is set at the same edge.
  - HEADER emits {HEADER_MAGIC, seq[15:0]}, where seq equals frame_cnt_out.
  - PAYLOAD emits word idx = 0..FRAME_WORDS-1 with value {seq[15:0], idx[15:0]}. It moves to TRAILER after idx = FRAME_WORDS-1 is emitted.
  - TRAILER emits the XOR of the header word and all payload words. It then goes to IDLE, clears busy_out and increments frame_cnt_out (0xFFFF wraps to 0x0000).
- **Emit rule:**
  - In HEADER, PAYLOAD or TRAILER, a word is emitted at a rising edge where pause_in = 0. At that edge data_out/valid_out are registered and the index, checksum and state advance.
  - At an edge where pause_in = 1, valid_out goes 0, and the state, index and checksum hold.
  - data_out holds its last value whenever valid_out = 0.
- **Checksum:** cleared on entry to HEADER. It accumulates every word emitted, including the header.
- **Reset mid-frame:** the frame is abandoned with no trailer. frame_cnt_out returns to 0.
- **Simultaneous events:** pause_in and a start request in the same cycle still enter HEADER, and the header waits for pause_in = 0. pause_in has no effect in IDLE.

## Timing
- **Trigger-to-output latency:** with trigger_in held high from edge 0, the header valid_out is high in cycle DEBOUNCE_CYCLES+4. This is 2 cycles for the synchronizer, DEBOUNCE_CYCLES for the debounce, 1 for the start edge/FSM and 1 for the output register.
- **Unpaused frame:** exactly FRAME_WORDS+2 consecutive valid_out cycles.
- **Pause effect:** each cycle that pause_in is sampled high inserts exactly one gap cycle.
- **Frame boundary:** busy_out falls and frame_cnt_out increments at the same edge that registers the trailer. Back-to-back frames therefore need a new debounced rising edge.
- **Debounce filtering:** glitches shorter than DEBOUNCE_CYCLES synchronized cycles never change the debounced level.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and FRAME_WORDS=4.

1. **Basic frame.** Reset, then hold trigger_in high.
   - Header valid in cycle 8: A5A5_0000.
   - Payload: 0000_0000, 0000_0001, 0000_0002, 0000_0003.
   - Trailer: A5A5_0000.
   - 6 consecutive valid cycles, then frame_cnt_out = 1 and busy_out = 0.
2. **Second frame.** Release for at least 6 cycles, then press again.
   - Header A5A5_0001.
   - Payload 0001_0000 .. 0001_0003.
   - Trailer A5A5_0001 (the payload XOR cancels).
   - frame_cnt_out = 2.
3. **Pause.** pause_in high for 3 cycles during payload idx 2.
   - Exactly 3 gap cycles; no word lost or duplicated.
   - data_out is stable during the gaps; trailer value unchanged.
4. **Glitch rejection and busy press.**
   - A 3-cycle trigger pulse produces no frame.
   - A new debounced press during a frame is ignored; only one frame is emitted.
5. **Reset mid-frame.** Assert rst_in during payload idx 1.
   - All outputs are 0 immediately (asynchronous).
   - After release and a press, the header is A5A5_0000.
6. **Wrap.** Force frame_cnt_out to 0xFFFF and complete a frame.
   - Header A5A5_FFFF.
   - frame_cnt_out becomes 0x0000.
